// File: rtl/riscv_test_pkg.sv
`default_nettype none
// riscv_test_pkg: shared state encoding and constants for the riscv-tests end-of-test monitor.
package riscv_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_PASS = 3'd2,
        ST_FAIL = 3'd3,
        ST_TMO  = 3'd4
    } state_t;

    localparam int unsigned RESULT_PASS = 1;
    localparam int unsigned MODE_PC     = 0;
    localparam int unsigned MODE_TOHOST = 1;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// sat_counter: up-counter that sticks at all-ones, with synchronous clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/riscv_test_monitor.sv
`default_nettype none
// riscv_test_monitor: snoops retire, register-file and store traffic to detect
// riscv-tests completion, decode pass/fail, and run a watchdog.
module riscv_test_monitor
    import riscv_test_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     MODE        = 0,
    parameter logic [XLEN-1:0] END_PC      = 'h44,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 'h1000,
    parameter int unsigned     GP_REG      = 3,
    parameter int unsigned     TIMEOUT     = 5000,
    parameter int unsigned     CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             retire_valid,
    input  logic [XLEN-1:0]  pc,
    input  logic             rf_we,
    input  logic [4:0]       rf_waddr,
    input  logic [XLEN-1:0]  rf_wdata,
    input  logic             st_valid,
    input  logic [XLEN-1:0]  st_addr,
    input  logic [XLEN-1:0]  st_data,
    output logic             done,
    output logic             passed,
    output logic             failed,
    output logic             timeout,
    output logic [XLEN-2:0]  test_num,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] gp_shadow;
    logic [XLEN-1:0] result;
    logic            gp_write;
    logic            in_run;
    logic            end_event;
    logic            wdog_hit;

    always_comb begin
        in_run   = (state == ST_RUN);
        gp_write = rf_we && (rf_waddr == 5'(GP_REG)) && (GP_REG != 0);
        if (MODE == MODE_TOHOST) begin
            end_event = in_run && st_valid && (st_addr == TOHOST_ADDR) && (st_data != '0);
            result    = st_data;
        end else begin
            end_event = in_run && retire_valid && (pc == END_PC);
            // A gp write landing with the end-PC retire must be visible to the decode.
            result    = gp_write ? rf_wdata : gp_shadow;
        end
        // Compared at 64 bits so a TIMEOUT beyond the counter range never fires.
        wdog_hit = in_run && (TIMEOUT != 0) &&
                   (64'(cycle_count) == (64'(TIMEOUT) - 64'd1));
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN: begin
                if (end_event) begin
                    state_next = (result == XLEN'(RESULT_PASS)) ? ST_PASS : ST_FAIL;
                end else if (wdog_hit) begin
                    state_next = ST_TMO;
                end
            end
            ST_PASS, ST_FAIL, ST_TMO: state_next = state;
            default: state_next = ST_IDLE;
        endcase
        if (clear) state_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            done     <= 1'b0;
            passed   <= 1'b0;
            failed   <= 1'b0;
            timeout  <= 1'b0;
            test_num <= '0;
        end else begin
            state   <= state_next;
            done    <= (state_next == ST_PASS) || (state_next == ST_FAIL) || (state_next == ST_TMO);
            passed  <= (state_next == ST_PASS);
            failed  <= (state_next == ST_FAIL);
            timeout <= (state_next == ST_TMO);
            if (state_next != ST_FAIL) begin
                test_num <= '0;
            end else if (state == ST_RUN) begin
                test_num <= result[XLEN-1:1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gp_shadow <= '0;
        end else if (gp_write) begin
            gp_shadow <= rf_wdata;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .en  (in_run),
        .q   (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .en  (in_run && retire_valid),
        .q   (retire_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_riscv_test_monitor.sv
`default_nettype none
// tb_riscv_test_monitor: three monitor configurations share one randomized stimulus
// stream and are compared each cycle against a behavioural model.
module tb_riscv_test_monitor;

    localparam int P_IDLE = 0, P_RUN = 1, P_PASS = 2, P_FAIL = 3, P_TMO = 4;

    typedef struct {
        int              phase;
        longint unsigned cyc;
        longint unsigned ret;
        longint unsigned gp;
        longint unsigned tnum;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst, start, clear, retire_valid, rf_we, st_valid;
    logic [31:0] pc, rf_wdata, st_addr, st_data;
    logic [4:0]  rf_waddr;

    logic [2:0]  done_v, pass_v, fail_v, tmo_v;
    logic [30:0] tn [3];
    logic [31:0] cyc [3];
    logic [31:0] ret [3];
    logic [3:0]  cyc_c, ret_c;

    mdl_t m [3];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // A: PC mode, watchdog 40. B: tohost mode, watchdog 16. C: PC mode, no watchdog, 4-bit counters.
    riscv_test_monitor #(.MODE(0), .TIMEOUT(40), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .retire_valid(retire_valid), .pc(pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .st_valid(st_valid),
        .st_addr(st_addr), .st_data(st_data), .done(done_v[0]), .passed(pass_v[0]),
        .failed(fail_v[0]), .timeout(tmo_v[0]), .test_num(tn[0]), .cycle_count(cyc[0]),
        .retire_count(ret[0]));

    riscv_test_monitor #(.MODE(1), .TIMEOUT(16), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .retire_valid(retire_valid), .pc(pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .st_valid(st_valid),
        .st_addr(st_addr), .st_data(st_data), .done(done_v[1]), .passed(pass_v[1]),
        .failed(fail_v[1]), .timeout(tmo_v[1]), .test_num(tn[1]), .cycle_count(cyc[1]),
        .retire_count(ret[1]));

    riscv_test_monitor #(.MODE(0), .TIMEOUT(0), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .retire_valid(retire_valid), .pc(pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .st_valid(st_valid),
        .st_addr(st_addr), .st_data(st_data), .done(done_v[2]), .passed(pass_v[2]),
        .failed(fail_v[2]), .timeout(tmo_v[2]), .test_num(tn[2]), .cycle_count(cyc_c),
        .retire_count(ret_c));

    assign cyc[2] = {28'd0, cyc_c};
    assign ret[2] = {28'd0, ret_c};

    function automatic int mode_of(int k);
        return (k == 1) ? 1 : 0;
    endfunction

    function automatic longint unsigned tmo_of(int k);
        return (k == 0) ? 64'd40 : (k == 1) ? 64'd16 : 64'd0;
    endfunction

    function automatic longint unsigned cmax_of(int k);
        return (k == 2) ? 64'd15 : 64'hFFFF_FFFF;
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.phase = P_IDLE; r.cyc = 0; r.ret = 0; r.gp = 0; r.tnum = 0;
        return r;
    endfunction

    // One clock of the reference behaviour, using the inputs held across the edge.
    function automatic mdl_t mdl_step(mdl_t cur, int k);
        mdl_t            nx = cur;
        bit              gpw = rf_we && (rf_waddr == 5'd3);
        bit              ev;
        longint unsigned res;
        if (clear) begin
            nx.phase = P_IDLE; nx.cyc = 0; nx.ret = 0;
        end else if (cur.phase == P_IDLE) begin
            if (start) nx.phase = P_RUN;
        end else if (cur.phase == P_RUN) begin
            if (mode_of(k) == 1) begin
                ev  = st_valid && (st_addr == 32'h1000) && (st_data != 0);
                res = st_data;
            end else begin
                ev  = retire_valid && (pc == 32'h44);
                res = gpw ? rf_wdata : cur.gp;
            end
            if (cur.cyc < cmax_of(k)) nx.cyc = cur.cyc + 1;
            if (retire_valid && cur.ret < cmax_of(k)) nx.ret = cur.ret + 1;
            if (ev) begin
                if (res == 1) nx.phase = P_PASS;
                else begin nx.phase = P_FAIL; nx.tnum = res >> 1; end
            end else if (tmo_of(k) != 0 && cur.cyc == tmo_of(k) - 1) begin
                nx.phase = P_TMO;
            end
        end
        if (gpw) nx.gp = rf_wdata;
        return nx;
    endfunction

    function automatic logic [127:0] mdl_pack(mdl_t x);
        logic [30:0] t = (x.phase == P_FAIL) ? 31'(x.tnum) : 31'd0;
        return {29'd0, x.phase >= P_PASS, x.phase == P_PASS, x.phase == P_FAIL,
                x.phase == P_TMO, t, 32'(x.cyc), 32'(x.ret)};
    endfunction

    function automatic logic [127:0] dut_pack(int k);
        return {29'd0, done_v[k], pass_v[k], fail_v[k], tmo_v[k], tn[k], cyc[k], ret[k]};
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("%s[%0d]", tag, k), dut_pack(k), mdl_pack(m[k]));
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        for (int k = 0; k < 3; k++) m[k] = mdl_step(m[k], k);
        #1;
        check_all(tag);
    endtask

    task automatic quiet();
        start = 0; clear = 0; retire_valid = 0; pc = 0; rf_we = 0; rf_waddr = 0;
        rf_wdata = 0; st_valid = 0; st_addr = 0; st_data = 0;
    endtask

    function automatic logic [31:0] pick(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
        case ($urandom_range(0, 3))
            0: return a;
            1: return b;
            2: return c;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        quiet();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) m[k] = mdl_reset();
        check_all("reset");
        rst = 0;

        // Bypass pass for A/C, tohost zero ignored then fail code for B.
        start = 1; tick("start");
        quiet(); rf_we = 1; rf_waddr = 3; rf_wdata = 7; tick("gp7");
        quiet(); st_valid = 1; st_addr = 32'h1000; st_data = 0; tick("tohost0");
        check_eq("tohost0_done", {127'd0, done_v[1]}, 128'd0);
        quiet(); rf_we = 1; rf_waddr = 3; rf_wdata = 1; retire_valid = 1; pc = 32'h44;
        tick("bypass");
        check_eq("bypass_pass", {126'd0, pass_v[0], fail_v[0]}, 128'd2);
        quiet(); st_valid = 1; st_addr = 32'h1000; st_data = 32'h15; tick("tohost15");
        check_eq("tohost15_tnum", {96'd0, fail_v[1], tn[1]}, {96'd0, 1'b1, 31'd10});

        quiet(); clear = 1; tick("clear");
        check_eq("clear_idle", {125'd0, done_v}, 128'd0);

        // Watchdog on B, saturation on C, end event winning over the watchdog on A.
        quiet(); start = 1; tick("rearm");
        quiet();
        for (int i = 0; i < 16; i++) tick("wd");
        check_eq("wd_b", {95'd0, tmo_v[1], cyc[1]}, {95'd0, 1'b1, 32'd16});
        check_eq("sat_c", {96'd0, cyc[2]}, 128'd15);
        for (int i = 0; i < 23; i++) tick("wd_a");
        rf_we = 1; rf_waddr = 3; rf_wdata = 32'hB; retire_valid = 1; pc = 32'h44;
        tick("ev_vs_wd");
        check_eq("ev_vs_wd_a", {93'd0, tmo_v[0], fail_v[0], tn[0], cyc[0]},
                 {93'd0, 1'b0, 1'b1, 31'd5, 32'd40});

        for (int i = 0; i < 3000; i++) begin
            start        = ($urandom_range(0, 7) == 0);
            clear        = ($urandom_range(0, 59) == 0);
            retire_valid = $urandom_range(0, 1);
            pc           = ($urandom_range(0, 24) == 0) ? 32'h44 : ($urandom_range(0, 255) & ~32'd3);
            rf_we        = $urandom_range(0, 1);
            rf_waddr     = ($urandom_range(0, 2) == 0) ? 5'd3 : 5'($urandom_range(0, 31));
            rf_wdata     = pick(32'd0, 32'd1, 32'hB);
            st_valid     = ($urandom_range(0, 9) == 0);
            st_addr      = ($urandom_range(0, 1) == 0) ? 32'h1000 : $urandom;
            st_data      = pick(32'd0, 32'd1, 32'h15);
            tick("rand");
            if ($urandom_range(0, 99) == 0) begin
                rst = 1;
                #1;
                for (int k = 0; k < 3; k++) m[k] = mdl_reset();
                check_all("async_rst");
                rst = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
